// File: rtl/delay_pipe_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pipe_arbiter_pkg
//  Description : Shared helpers for the delay-pipe arbiter slice. Holds the
//                elaboration-time log2 helper used to size ID and counter
//                fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_pipe_arbiter_pkg;

    // Ceiling log2 evaluated at elaboration; returns 0 for values <= 1.
    function automatic int dpa_clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage : delay_pipe_arbiter_pkg
`default_nettype wire

// File: rtl/delay_pipe_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans indices starting at
//                the pointer, wrapping modulo NREQ, and selects the first
//                eligible one. Produces a one-hot grant and its encoded index
//                (index is 0 when nothing is granted).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import delay_pipe_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = dpa_clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx,
    output logic            o_grant_any
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam logic [IDW:0] c_nreq = (IDW+1)'(NREQ);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_sel;

    // Walk the ring from the pointer; the first eligible index wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_sum       = '0;
        w_sel       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            w_sel = w_sum[IDW-1:0];
            if (!o_grant_any && i_eligible[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                o_grant_idx    = w_sel;
                o_grant_any    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/delay_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pipe_arbiter
//  Description : Shares a fixed-latency, non-stalling pipelined datapath
//                between NREQ requesters. Grants at most one issue per cycle
//                in round-robin order, follows each issue through a LATENCY
//                deep tag pipeline and pulses the owner's done line when its
//                result leaves the datapath. A per-requester outstanding
//                counter caps in-flight work at MAX_OUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_pipe_arbiter
    import delay_pipe_arbiter_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int LATENCY = 3,
    parameter  int MAX_OUT = 2,
    localparam int IDW     = dpa_clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            unit_valid,
    output logic [IDW-1:0]  unit_sel,
    output logic [NREQ-1:0] done,
    output logic [IDW-1:0]  done_id,
    output logic            busy
);

    localparam int             c_cnt_w    = dpa_clog2(MAX_OUT + 1);
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUT);
    localparam logic [IDW-1:0] c_last_idx = IDW'(NREQ - 1);

    logic [IDW-1:0]     r_ptr;
    logic [NREQ-1:0]    w_eligible;
    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_grant_any;
    logic [LATENCY-1:0] r_tag_valid;
    logic [IDW-1:0]     r_tag_id [LATENCY];
    logic [c_cnt_w-1:0] r_out_cnt [NREQ];

    // Eligibility uses the registered count only, so a same-cycle done never
    // feeds back into grant. Gating with rst_n forces grant low in reset.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign w_eligible[gi] = rst_n & req[gi] & (r_out_cnt[gi] < c_max_out);
        end
    endgenerate

    rr_arbiter #(
        .NREQ        (NREQ)
    ) u_rr_arbiter (
        .i_eligible  (w_eligible),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    assign grant      = w_grant;
    assign unit_valid = w_grant_any;
    assign unit_sel   = w_grant_idx;

    // Round-robin pointer moves just past the winner; holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_grant_any) begin
            r_ptr <= (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + IDW'(1);
        end
    end

    // Tag pipeline mirrors the datapath stages; it never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_valid <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_valid[0] <= w_grant_any;
            r_tag_id[0]    <= w_grant_idx;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag_valid[s] <= r_tag_valid[s-1];
                r_tag_id[s]    <= r_tag_id[s-1];
            end
        end
    end

    // Decode the last tag stage into the one-hot done pulse and its index.
    always_comb begin
        done    = '0;
        done_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            done[i] = r_tag_valid[LATENCY-1] && (r_tag_id[LATENCY-1] == IDW'(i));
        end
        if (r_tag_valid[LATENCY-1]) begin
            done_id = r_tag_id[LATENCY-1];
        end
    end

    // Per-requester outstanding counters: +1 on issue, -1 on completion.
    generate
        for (genvar gc = 0; gc < NREQ; gc++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out_cnt[gc] <= '0;
                end else begin
                    case ({w_grant[gc], done[gc]})
                        2'b10:   r_out_cnt[gc] <= r_out_cnt[gc] + c_cnt_w'(1);
                        2'b01:   r_out_cnt[gc] <= r_out_cnt[gc] - c_cnt_w'(1);
                        default: r_out_cnt[gc] <= r_out_cnt[gc];
                    endcase
                end
            end
        end
    endgenerate

    assign busy = |r_tag_valid;

endmodule : delay_pipe_arbiter
`default_nettype wire
